// File: rtl/add_sub_chunked.sv
// Multi-cycle add/subtract unit: evaluates CHUNK bits per clock, LSB chunk first,
// with the inter-chunk carry held in a register. Valid/ready on both sides.
module add_sub_chunked #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("add_sub_chunked: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   sum;
    logic             msb_carry_in;

    // Operands shift right each RUN cycle so the active chunk is always at bit 0;
    // the result shifts in from the top and lands in place after NCHUNK steps.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        carry_d      = carry_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        r_d          = r_q;
        cout_d       = cout_q;
        ovf_d        = ovf_q;
        zero_d       = zero_q;
        a_chunk      = opa_q[CHUNK-1:0];
        b_chunk      = opb_q[CHUNK-1:0];
        sum          = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum[CHUNK-1];

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    opa_d = a;
                    opb_d = op[0] ? ~b : b;
                    unique case (op)
                        2'b00:   carry_d = 1'b0;
                        2'b01:   carry_d = 1'b1;
                        default: carry_d = cin;
                    endcase
                    k_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                r_d                     = r_q >> CHUNK;
                r_d[WIDTH-1 -: CHUNK]   = sum[CHUNK-1:0];
                opa_d                   = opa_q >> CHUNK;
                opb_d                   = opb_q >> CHUNK;
                carry_d                 = sum[CHUNK];
                k_d                     = k_q + 1'b1;
                if (k_q == KW'(NCHUNK - 1)) begin
                    cout_d  = sum[CHUNK];
                    ovf_d   = msb_carry_in ^ sum[CHUNK];
                    zero_d  = (r_d == '0);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            r_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            r_q     <= r_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign r         = r_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_add_sub_chunked.sv
// Directed bench for add_sub_chunked: three instances (CHUNK 8, 32, 1) share operands,
// each with its own handshake; expected values are hand-computed constants.
module tb_add_sub_chunked;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        cin;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] r_o       [3];
    logic        cout_o    [3];
    logic        ovf_o     [3];
    logic        zero_o    [3];

    int n_checks = 0;
    int n_errors = 0;

    add_sub_chunked #(.WIDTH(32), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .r(r_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0]),
        .zero(zero_o[0])
    );

    add_sub_chunked #(.WIDTH(32), .CHUNK(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .r(r_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1]),
        .zero(zero_o[1])
    );

    add_sub_chunked #(.WIDTH(32), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .r(r_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2]),
        .zero(zero_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one op on instance d, wait (bounded) for out_valid, check latency and result.
    // With out_ready high the handshake completes on the next edge and is checked too.
    task automatic do_op(input int d, input string tag, input logic [1:0] op_v,
                         input logic [31:0] a_v, input logic [31:0] b_v, input logic cin_v,
                         input logic [31:0] exp_r, input logic exp_c, input logic exp_v,
                         input logic exp_z, input int exp_lat);
        int lat;
        a  = a_v;
        b  = b_v;
        op = op_v;
        cin = cin_v;
        check_eq({tag, "_in_ready"}, 64'(in_ready[d]), 64'd1);
        in_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        a  = 32'hDEAD_BEEF;
        b  = 32'hCAFE_F00D;
        lat = 0;
        while (!out_valid[d] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_r"}, 64'(r_o[d]), 64'(exp_r));
        check_eq({tag, "_cout"}, 64'(cout_o[d]), 64'(exp_c));
        check_eq({tag, "_ovf"}, 64'(ovf_o[d]), 64'(exp_v));
        check_eq({tag, "_zero"}, 64'(zero_o[d]), 64'(exp_z));
        if (out_ready[d]) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_out_valid_drop"}, 64'(out_valid[d]), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        a   = '0;
        b   = '0;
        op  = 2'b00;
        cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready[0]), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid[0]), 64'd0);
        check_eq("rst_r", 64'(r_o[0]), 64'd0);
        check_eq("rst_flags", 64'({cout_o[0], ovf_o[0], zero_o[0]}), 64'd0);

        do_op(0, "add_wrap",  2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1, 0, 1, 4);
        do_op(0, "sub_5_7",   2'b01, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 0, 0, 0, 4);
        do_op(0, "sub_7_5",   2'b01, 32'h0000_0007, 32'h0000_0005, 1'b0, 32'h0000_0002, 1, 0, 0, 4);
        do_op(0, "add_ovf",   2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 0, 1, 0, 4);
        do_op(0, "sub_ovf",   2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1, 1, 0, 4);
        do_op(0, "adc_cross", 2'b10, 32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0100, 0, 0, 0, 4);
        do_op(0, "sbb_borrow", 2'b11, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'h0000_00FF, 1, 0, 0, 4);

        // Backpressure: result must hold while out_ready is low.
        out_ready[0] = 1'b0;
        do_op(0, "bp", 2'b00, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 0, 0, 0, 4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_hold_valid", 64'(out_valid[0]), 64'd1);
            check_eq("bp_hold_r", 64'(r_o[0]), 64'h2345_6789);
            check_eq("bp_hold_in_ready", 64'(in_ready[0]), 64'd0);
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_release_valid", 64'(out_valid[0]), 64'd0);
        check_eq("bp_release_in_ready", 64'(in_ready[0]), 64'd1);
        do_op(0, "bp_next", 2'b00, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 0, 0, 0, 4);

        // Reset two RUN cycles into an op whose partial result is non-zero.
        a  = 32'h1111_1111;
        b  = 32'h1111_1111;
        op = 2'b00;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_out_valid", 64'(out_valid[0]), 64'd0);
        check_eq("mid_rst_r", 64'(r_o[0]), 64'd0);
        check_eq("mid_rst_flags", 64'({cout_o[0], ovf_o[0], zero_o[0]}), 64'd0);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_in_ready", 64'(in_ready[0]), 64'd1);
        check_eq("post_rst_out_valid", 64'(out_valid[0]), 64'd0);
        do_op(0, "post_rst_add", 2'b00, 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 0, 0, 0, 4);

        do_op(1, "c32_add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 1, 0, 1, 1);
        do_op(1, "c32_sub_ovf",  2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1, 1, 0, 1);
        do_op(2, "c1_add_wrap",  2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 1, 0, 1, 32);
        do_op(2, "c1_add_ovf",   2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 0, 1, 0, 32);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/add_sub_chunked.md
Name: add_sub_chunked

Overview:
- Parametrised successor to the team's fixed 8-bit adder.
- Multi-cycle add/subtract unit of WIDTH bits. Evaluates the operation CHUNK bits per clock, least-significant chunk first, rippling the carry through a register between chunks.
- Valid/ready handshakes on input and output, so it drops into datapaths that cannot close timing on a full-width adder.
- Reports carry-out, signed overflow and zero flags.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (derived, localparam), WIDTH/CHUNK, cycles per operation.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  unit can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  2  00 ADD a+b; 01 SUB a-b; 10 ADC a+b+cin; 11 SBB a+~b+cin (cin=1 means no borrow).
- cin  in  1  carry-in, used only for ADC/SBB.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer accepts result.
- r  out  WIDTH  result.
- cout  out  1  carry out of MSB. For SUB/SBB, 1 = no borrow (a >= b unsigned for SUB).
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  r == 0.

Behaviour:
- Reset (async, any state, including mid-operation):
  - State goes to IDLE; the operation in flight is discarded.
  - in_ready=1 once rst deasserts.
  - out_valid=0, r=0, cout=0, ovf=0, zero=0; chunk counter=0, carry register=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: latch a into opa.
  - Latch b into opb, inverted when op[0]=1.
  - Load carry register with: 0 (ADD), 1 (SUB), cin (ADC/SBB).
  - Clear counter k; go to RUN.
- RUN:
  - in_ready=0. Input port changes are ignored (operands already latched).
  - Each cycle: {c, s} = opa[k*CHUNK +: CHUNK] + opb[k*CHUNK +: CHUNK] + carry.
  - Write s into r[k*CHUNK +: CHUNK]; carry <= c; k <= k+1.
  - On the last chunk (k == NCHUNK-1):
    - cout <= c.
    - ovf <= carry into MSB XOR carry out of MSB, computed from the final chunk's top bit.
    - zero <= (full registered result, including the final chunk, == 0).
    - Go to DONE.
- DONE:
  - out_valid=1. r and flags are held stable until the handshake.
  - On out_valid && out_ready: go to IDLE, out_valid=0 next cycle. r and flags keep their values until the next op overwrites them.
- Latency and throughput:
  - out_valid rises exactly NCHUNK clock edges after the accepting edge.
  - With out_ready held high: one operation per NCHUNK+2 cycles (IDLE accept, NCHUNK RUN, DONE).
  - CHUNK==WIDTH gives one RUN cycle.
- r is unspecified while out_valid=0 after the first op; the bench checks r only while out_valid=1.
- Widths: carry and chunk arithmetic are exactly CHUNK+1 bits; there is no wider intermediate sum.
- k width: max(1, $clog2(NCHUNK)).
- Illegal parameters (WIDTH % CHUNK != 0) stop elaboration via a static assertion.
- Backpressure: out_ready low holds DONE indefinitely; in_ready stays 0; no operation is lost or duplicated.
- Simultaneous in_valid in RUN/DONE: not accepted; the producer holds in_valid/operands until in_ready=1.

Test Plan:
Run all tests with WIDTH=32, CHUNK=8 unless stated.
1. ADD a=0xFFFFFFFF, b=0x00000001 -> out_valid 4 edges after accept; r=0x00000000, cout=1, zero=1, ovf=0.
2. SUB a=0x00000005, b=0x00000007 -> r=0xFFFFFFFE, cout=0 (borrow), ovf=0, zero=0. SUB a=7, b=5 -> r=2, cout=1.
3. ADD a=0x7FFFFFFF, b=0x00000001 -> r=0x80000000, ovf=1, cout=0. SUB a=0x80000000, b=1 -> r=0x7FFFFFFF, ovf=1, cout=1.
4. ADC a=0x000000FF, b=0, cin=1 -> r=0x00000100 (carry crosses chunk 0->1). SBB a=0x100, b=0, cin=0 -> r=0x000000FF, cout=1.
5. Backpressure: ADD 0x12345678 + 0x11111111 with out_ready=0 for 5 cycles.
   - Expect r=0x23456789, out_valid=1 and r stable throughout, in_ready=0.
   - Raise out_ready -> IDLE next cycle; next op accepted.
6. Reset and corner configuration:
   - Assert rst after 2 RUN cycles -> immediately out_valid=0, r=0, flags 0; in_ready=1 after release.
   - Follow-up ADD 3+4 -> r=7.
   - Repeat test 1 with CHUNK=32 (1-cycle RUN) and CHUNK=1 (32 cycles).
